pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage F/D/E/M/W pipeline. It sits directly downstream of the operand forwarding unit and consumes its `load_wait` request. It also takes the execute-stage branch redirect and the instruction and data bus handshakes. Every cycle it drives the load-enable and bubble-insert controls of the PC and of the FD/DE/EM/MW pipeline registers. It tracks in-flight fetches that a redirect has made stale, and keeps two hazard event counters.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_ctrl_event_counter.sv | 25 ++
 rtl/pipeline_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
//   fetch_state_t : fetch FSM state. F_DROP means an in-flight fetch is stale.
//   pipe_ctrl_t   : load-enable / bubble-insert pair for one pipeline register.
package pipes;

    typedef enum logic [0:0] {F_IDLE, F_DROP} fetch_state_t;

    typedef struct packed {
        logic en;
        logic bubble;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_event_counter.sv
// Wrapping event counter.
//   clk, reset : clock and synchronous active-high reset
//   inc        : count one event this cycle
//   count      : registered count, modulo 2^CNT_W
module event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (inc)
            r_count <= r_count + CNT_W'(1);
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the F/D/E/M/W pipeline.
// Inputs : clk, reset (sync, active high), load_wait, e_redirect,
//          i_req/i_data_ok (fetch bus), d_req/d_data_ok (data bus).
// Outputs: pc_en, pc_sel_redirect, {fd,de,em,mw}_{en,bubble},
//          fetch_drop, cnt_load_stall, cnt_redirect.
// Controls are combinational from inputs and the fetch FSM state; the FSM
// and counters update on the rising edge.
module pipeline_ctrl
    import pipes::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_wait,
    input  logic             e_redirect,
    input  logic             i_req,
    input  logic             i_data_ok,
    input  logic             d_req,
    input  logic             d_data_ok,
    output logic             pc_en,
    output logic             pc_sel_redirect,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_bubble,
    output logic             de_bubble,
    output logic             em_bubble,
    output logic             mw_bubble,
    output logic             fetch_drop,
    output logic [CNT_W-1:0] cnt_load_stall,
    output logic [CNT_W-1:0] cnt_redirect
);

    fetch_state_t r_state, w_state_nxt;
    pipe_ctrl_t   w_fd, w_de, w_em, w_mw;
    logic         w_pc_en, w_pc_sel, w_fetch_drop;
    logic         w_inc_load, w_inc_redir;
    logic         w_mem_stall, w_fetch_stall;

    assign w_mem_stall   = d_req & ~d_data_ok;
    assign w_fetch_stall = (i_req & ~i_data_ok) | (r_state == F_DROP);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= F_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_en      = 1'b0;
        w_pc_sel     = 1'b0;
        w_fd         = '0;
        w_de         = '0;
        w_em         = '0;
        w_mw         = '0;
        w_fetch_drop = 1'b0;
        w_inc_load   = 1'b0;
        w_inc_redir  = 1'b0;

        if (reset) begin
            w_fd        = '{en: 1'b1, bubble: 1'b1};
            w_de        = '{en: 1'b1, bubble: 1'b1};
            w_em        = '{en: 1'b1, bubble: 1'b1};
            w_mw        = '{en: 1'b1, bubble: 1'b1};
            w_state_nxt = F_IDLE;
        end else begin
            if (w_mem_stall) begin
                // E is frozen; redirect / load_wait are re-presented later
                w_mw = '{en: 1'b1, bubble: 1'b1};
            end else if (e_redirect) begin
                w_pc_en     = 1'b1;
                w_pc_sel    = 1'b1;
                w_fd        = '{en: 1'b1, bubble: 1'b1};
                w_de        = '{en: 1'b1, bubble: 1'b1};
                w_em.en     = 1'b1;
                w_mw.en     = 1'b1;
                w_inc_redir = 1'b1;
                // The old fetch stays on the bus until i_data_ok; remember
                // to discard it. A response arriving now is squashed by
                // fd_bubble instead.
                if (r_state == F_IDLE && i_req && !i_data_ok)
                    w_state_nxt = F_DROP;
            end else if (load_wait) begin
                w_de       = '{en: 1'b1, bubble: 1'b1};
                w_em.en    = 1'b1;
                w_mw.en    = 1'b1;
                w_inc_load = 1'b1;
            end else if (w_fetch_stall) begin
                w_fd    = '{en: 1'b1, bubble: 1'b1};
                w_de.en = 1'b1;
                w_em.en = 1'b1;
                w_mw.en = 1'b1;
            end else begin
                w_pc_en = 1'b1;
                w_fd.en = 1'b1;
                w_de.en = 1'b1;
                w_em.en = 1'b1;
                w_mw.en = 1'b1;
            end

            // Stale response leaves regardless of any stall in progress
            if (r_state == F_DROP) begin
                w_fetch_drop = i_data_ok;
                if (w_fd.en)
                    w_fd.bubble = 1'b1;
                if (i_data_ok)
                    w_state_nxt = F_IDLE;
            end
        end
    end

    assign pc_en           = w_pc_en;
    assign pc_sel_redirect = w_pc_sel;
    assign fd_en           = w_fd.en;
    assign fd_bubble       = w_fd.bubble;
    assign de_en           = w_de.en;
    assign de_bubble       = w_de.bubble;
    assign em_en           = w_em.en;
    assign em_bubble       = w_em.bubble;
    assign mw_en           = w_mw.en;
    assign mw_bubble       = w_mw.bubble;
    assign fetch_drop      = w_fetch_drop;

    event_counter #(.CNT_W(CNT_W)) u_cnt_load (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc_load),
        .count (cnt_load_stall)
    );

    event_counter #(.CNT_W(CNT_W)) u_cnt_redirect (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc_redir),
        .count (cnt_redirect)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, load_wait, e_redirect, i_req, i_data_ok, d_req, d_data_ok;

    // full-width instance
    logic        pc_en, pc_sel, fd_en, de_en, em_en, mw_en;
    logic        fd_b, de_b, em_b, mw_b, fdrop;
    logic [31:0] cnt_l, cnt_r;
    // narrow-counter instance so wrap-around is reached quickly
    logic        s_pc_en, s_pc_sel, s_fd_en, s_de_en, s_em_en, s_mw_en;
    logic        s_fd_b, s_de_b, s_em_b, s_mw_b, s_fdrop;
    logic [2:0]  s_cnt_l, s_cnt_r;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset), .load_wait(load_wait), .e_redirect(e_redirect),
        .i_req(i_req), .i_data_ok(i_data_ok), .d_req(d_req), .d_data_ok(d_data_ok),
        .pc_en(pc_en), .pc_sel_redirect(pc_sel),
        .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_bubble(fd_b), .de_bubble(de_b), .em_bubble(em_b), .mw_bubble(mw_b),
        .fetch_drop(fdrop), .cnt_load_stall(cnt_l), .cnt_redirect(cnt_r)
    );

    pipeline_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .load_wait(load_wait), .e_redirect(e_redirect),
        .i_req(i_req), .i_data_ok(i_data_ok), .d_req(d_req), .d_data_ok(d_data_ok),
        .pc_en(s_pc_en), .pc_sel_redirect(s_pc_sel),
        .fd_en(s_fd_en), .de_en(s_de_en), .em_en(s_em_en), .mw_en(s_mw_en),
        .fd_bubble(s_fd_b), .de_bubble(s_de_b), .em_bubble(s_em_b), .mw_bubble(s_mw_b),
        .fetch_drop(s_fdrop), .cnt_load_stall(s_cnt_l), .cnt_redirect(s_cnt_r)
    );

    // ctl bit order: {pc_en, pc_sel, fd_en, fd_b, de_en, de_b, em_en, em_b, mw_en, mw_b, fetch_drop}
    typedef struct {
        logic [10:0] ctl;
        logic        chk_cnt;
        logic [31:0] cl, cr;
        logic [2:0]  cl3, cr3;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // reference model: "a stale fetch is pending" flag and event totals
    bit          m_stale = 1'b0;
    bit          m_known = 1'b0;
    logic [31:0] m_cl = '0, m_cr = '0;
    logic [2:0]  m_cl3 = '0, m_cr3 = '0;

    typedef enum int {A_RST, A_MEM, A_RED, A_LOAD, A_FETCH, A_RUN} act_t;

    task automatic drive(input bit rst, input bit lw, input bit er, input bit ir,
                         input bit iok, input bit dr, input bit dok);
        act_t  a;
        exp_t  e;
        @(posedge clk);
        #1;
        reset = rst; load_wait = lw; e_redirect = er;
        i_req = ir; i_data_ok = iok; d_req = dr; d_data_ok = dok;

        if (rst)                         a = A_RST;
        else if (dr && !dok)             a = A_MEM;
        else if (er)                     a = A_RED;
        else if (lw)                     a = A_LOAD;
        else if ((ir && !iok) || m_stale) a = A_FETCH;
        else                             a = A_RUN;

        case (a)
            A_RST:   e.ctl = 11'b00_11_11_11_11_0;
            A_MEM:   e.ctl = 11'b00_00_00_00_11_0;
            A_RED:   e.ctl = 11'b11_11_11_10_10_0;
            A_LOAD:  e.ctl = 11'b00_00_11_10_10_0;
            A_FETCH: e.ctl = 11'b00_11_10_10_10_0;
            default: e.ctl = 11'b10_10_10_10_10_0;
        endcase
        if (a != A_RST && m_stale) begin
            e.ctl[0] = iok;
            if (e.ctl[8]) e.ctl[7] = 1'b1;
        end
        e.chk_cnt = m_known;
        e.cl = m_cl; e.cr = m_cr; e.cl3 = m_cl3; e.cr3 = m_cr3;
        q.push_back(e);

        // advance model to the state after the coming edge
        if (a == A_RST) begin
            m_stale = 1'b0; m_known = 1'b1;
            m_cl = '0; m_cr = '0; m_cl3 = '0; m_cr3 = '0;
        end else begin
            if (m_stale) m_stale = !iok;
            else         m_stale = (a == A_RED) && ir && !iok;
            if (a == A_LOAD) begin m_cl = m_cl + 1; m_cl3 = m_cl3 + 1; end
            if (a == A_RED)  begin m_cr = m_cr + 1; m_cr3 = m_cr3 + 1; end
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [10:0] c, cs;
        if (q.size() > 0) begin
            e  = q.pop_front();
            c  = {pc_en, pc_sel, fd_en, fd_b, de_en, de_b, em_en, em_b, mw_en, mw_b, fdrop};
            cs = {s_pc_en, s_pc_sel, s_fd_en, s_fd_b, s_de_en, s_de_b,
                  s_em_en, s_em_b, s_mw_en, s_mw_b, s_fdrop};
            check32("ctl", 32'(c), 32'(e.ctl));
            check32("ctl_small", 32'(cs), 32'(e.ctl));
            check32("bubble_needs_en", 32'({fd_b, de_b, em_b, mw_b} & ~{fd_en, de_en, em_en, mw_en}), 32'd0);
            if (e.chk_cnt) begin
                check32("cnt_load_stall", cnt_l, e.cl);
                check32("cnt_redirect", cnt_r, e.cr);
                check32("cnt_load_stall_w3", 32'(s_cnt_l), 32'(e.cl3));
                check32("cnt_redirect_w3", 32'(s_cnt_r), 32'(e.cr3));
            end
        end
    end

    initial begin
        reset = 1'b1; load_wait = 0; e_redirect = 0;
        i_req = 0; i_data_ok = 0; d_req = 0; d_data_ok = 0;

        drive(1,0,0,0,0,0,0);
        drive(1,0,0,0,0,0,0);
        drive(0,0,0,0,0,0,0);
        // single load-use stall
        drive(0,1,0,0,0,0,0);
        drive(0,0,0,0,0,0,0);
        // memory stall hides a pending redirect, then accepts it
        repeat (3) drive(0,0,1,0,0,1,0);
        drive(0,0,1,0,0,1,1);
        drive(0,0,0,0,0,0,0);
        // redirect while a fetch is outstanding; stale word arrives later
        drive(0,0,1,1,0,0,0);
        drive(0,0,0,1,0,0,0);
        drive(0,0,0,1,1,0,0);
        drive(0,0,0,0,0,0,0);
        // redirect in the same cycle as the fetch response
        drive(0,0,1,1,1,0,0);
        drive(0,0,0,0,0,0,0);
        // bring both counters to 5, enter stale state, then reset
        while (m_cl != 5) drive(0,1,0,0,0,0,0);
        while (m_cr != 4) drive(0,0,1,0,0,0,0);
        drive(0,0,1,1,0,0,0);
        drive(1,0,0,1,0,0,0);
        drive(0,0,0,1,1,0,0);
        drive(0,0,0,0,0,0,0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0));
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
